address_map_prog: RTL

- Programmable successor to the fixed SNES address decoder.
- Translates SNES_ADDR into an SRAM0 address and ROM/SaveRAM/writable attributes using NUM_REGIONS MCU-programmed windows. A window can be a ROM bank, a SaveRAM window or a bank-switched mirror.
- Configuration is double-buffered: the MCU writes a shadow register set, and a commit copies it to the active set only while the SNES bus is idle.
- Sits between the SNES bus sampling logic and the SRAM0 arbiter. It replaces the hard-wired mapper equations for new mappers.

---
 rtl/addr_map_pkg.sv | 24 ++
 rtl/addr_map_prio_enc.sv | 24 ++
 rtl/address_map_prog.sv | 265 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/addr_map_pkg.sv
// addr_map_pkg: config field encodings, attribute bit positions and
// the packed region record shared by the programmable address map.
package addr_map_pkg;

  localparam int MAP_AW = 24;

  localparam logic [1:0] SEL_BASE   = 2'd0;
  localparam logic [1:0] SEL_MASK   = 2'd1;
  localparam logic [1:0] SEL_OFFSET = 2'd2;
  localparam logic [1:0] SEL_ATTR   = 2'd3;

  localparam int ATTR_EN   = 0;
  localparam int ATTR_ROM  = 1;
  localparam int ATTR_SRAM = 2;
  localparam int ATTR_WR   = 3;

  typedef struct packed {
    logic [MAP_AW-1:0] base;
    logic [MAP_AW-1:0] mask;
    logic [MAP_AW-1:0] offset;
    logic [3:0]        attr;
  } region_t;

endpackage

// File: rtl/addr_map_prio_enc.sv
// addr_map_prio_enc: lowest-index-wins priority encoder.
// Ports: req (request vector) -> idx (winner), valid (any request).
module addr_map_prio_enc #(
  parameter int N     = 8,
  parameter int IDX_W = 3
) (
  input  logic [N-1:0]     req,
  output logic [IDX_W-1:0] idx,
  output logic             valid
);

  // Scan downwards so the lowest set index is the last one written.
  always_comb begin
    idx   = '0;
    valid = 1'b0;
    for (int i = N - 1; i >= 0; i--) begin
      if (req[i]) begin
        idx   = IDX_W'(i);
        valid = 1'b1;
      end
    end
  end

endmodule

// File: rtl/address_map_prog.sv
// address_map_prog: programmable SNES->SRAM0 address map, double-buffered
// config (CFG_*), 2-stage decode (SNES_* -> ROM_ADDR/IS_*/HIT_*).
// Optional per-region hit counters (HITCNT_*) with ADDRMAP_HITCNT_EN.
module address_map_prog
  import addr_map_pkg::*;
#(
  parameter int NUM_REGIONS = 8,
  parameter int ADDR_W      = MAP_AW,
  parameter int IDX_W       = (NUM_REGIONS > 1) ? $clog2(NUM_REGIONS) : 1
) (
  input  logic              CLK,
  input  logic              RST_N,
  input  logic [ADDR_W-1:0] SNES_ADDR,
  input  logic              SNES_ACCESS,
  input  logic              SNES_IDLE,
  input  logic [ADDR_W-1:0] ROM_MASK,
  input  logic [ADDR_W-1:0] SAVERAM_MASK,
  input  logic              CFG_WE,
  input  logic [IDX_W-1:0]  CFG_IDX,
  input  logic [1:0]        CFG_SEL,
  input  logic [ADDR_W-1:0] CFG_DATA,
  input  logic              CFG_COMMIT,
  output logic              CFG_BUSY,
  output logic [ADDR_W-1:0] ROM_ADDR,
  output logic              ROM_HIT,
  output logic              IS_ROM,
  output logic              IS_SAVERAM,
  output logic              IS_WRITABLE,
  output logic [IDX_W-1:0]  HIT_IDX,
  output logic              HIT_VALID,
  input  logic [IDX_W-1:0]  HITCNT_IDX,
  output logic [15:0]       HITCNT_DATA
);

  region_t shadow_q [NUM_REGIONS];
  region_t shadow_d [NUM_REGIONS];
  region_t active_q [NUM_REGIONS];
  region_t active_d [NUM_REGIONS];

  logic pending_q;
  logic pending_d;
  logic commit_req;
  logic copy;
  logic cfg_idx_ok;

  assign cfg_idx_ok = 32'(CFG_IDX) < 32'(NUM_REGIONS);

  always_comb begin
    shadow_d = shadow_q;
    if (CFG_WE && cfg_idx_ok) begin
      unique case (CFG_SEL)
        SEL_BASE:   shadow_d[CFG_IDX].base   = CFG_DATA;
        SEL_MASK:   shadow_d[CFG_IDX].mask   = CFG_DATA;
        SEL_OFFSET: shadow_d[CFG_IDX].offset = CFG_DATA;
        SEL_ATTR:   shadow_d[CFG_IDX].attr   = CFG_DATA[3:0];
        default:    shadow_d = shadow_q;
      endcase
    end
  end

  // A commit request folds into any pending one; the copy waits for
  // an idle bus and always takes the pre-edge shadow contents.
  assign commit_req = pending_q | CFG_COMMIT;
  assign copy       = commit_req & SNES_IDLE;

  always_comb begin
    pending_d = commit_req & ~SNES_IDLE;
    active_d  = active_q;
    if (copy) begin
      active_d = shadow_q;
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      for (int i = 0; i < NUM_REGIONS; i++) begin
        shadow_q[i] <= '0;
        active_q[i] <= '0;
      end
      pending_q <= 1'b0;
    end else begin
      shadow_q  <= shadow_d;
      active_q  <= active_d;
      pending_q <= pending_d;
    end
  end

  assign CFG_BUSY = pending_q;

  logic [NUM_REGIONS-1:0] hit_vec;
  logic [IDX_W-1:0]       enc_idx;
  logic                   enc_valid;

  always_comb begin
    hit_vec = '0;
    for (int r = 0; r < NUM_REGIONS; r++) begin
      hit_vec[r] = active_q[r].attr[ATTR_EN] &
        (((SNES_ADDR ^ active_q[r].base) &
          active_q[r].mask) == '0);
    end
  end

  addr_map_prio_enc #(
    .N     (NUM_REGIONS),
    .IDX_W (IDX_W)
  ) u_prio_enc (
    .req   (hit_vec),
    .idx   (enc_idx),
    .valid (enc_valid)
  );

  logic [NUM_REGIONS-1:0] s1_hit_q;
  logic [NUM_REGIONS-1:0] s1_hit_d;
  logic [IDX_W-1:0]       s1_idx_q;
  logic [IDX_W-1:0]       s1_idx_d;
  logic [ADDR_W-1:0]      s1_inner_q;
  logic [ADDR_W-1:0]      s1_inner_d;
  logic [ADDR_W-1:0]      s1_off_q;
  logic [ADDR_W-1:0]      s1_off_d;
  logic [2:0]             s1_attr_q;
  logic [2:0]             s1_attr_d;
  logic [ADDR_W-1:0]      size_mask;

  // The winner's window fields are captured alongside the address so a
  // commit landing between the stages cannot mix two maps in one result.
  // s1_attr bit order: {writable, saveram, rom}.
  always_comb begin
    s1_hit_d   = hit_vec;
    s1_idx_d   = enc_idx;
    s1_inner_d = '0;
    s1_off_d   = '0;
    s1_attr_d  = '0;
    size_mask  = active_q[enc_idx].attr[ATTR_SRAM] ?
                 SAVERAM_MASK : ROM_MASK;
    if (enc_valid) begin
      s1_inner_d = SNES_ADDR & ~active_q[enc_idx].mask & size_mask;
      s1_off_d   = active_q[enc_idx].offset;
      s1_attr_d  = {active_q[enc_idx].attr[ATTR_WR],
                    active_q[enc_idx].attr[ATTR_SRAM],
                    active_q[enc_idx].attr[ATTR_ROM]};
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      s1_hit_q   <= '0;
      s1_idx_q   <= '0;
      s1_inner_q <= '0;
      s1_off_q   <= '0;
      s1_attr_q  <= '0;
    end else begin
      s1_hit_q   <= s1_hit_d;
      s1_idx_q   <= s1_idx_d;
      s1_inner_q <= s1_inner_d;
      s1_off_q   <= s1_off_d;
      s1_attr_q  <= s1_attr_d;
    end
  end

  logic [ADDR_W-1:0] rom_addr_q;
  logic [ADDR_W-1:0] rom_addr_d;
  logic              rom_hit_q;
  logic              rom_hit_d;
  logic              is_rom_q;
  logic              is_rom_d;
  logic              is_sram_q;
  logic              is_sram_d;
  logic              is_wr_q;
  logic              is_wr_d;
  logic [IDX_W-1:0]  hit_idx_q;
  logic [IDX_W-1:0]  hit_idx_d;
  logic              hit_valid_q;
  logic              hit_valid_d;

  // Stage-1 fields are already zero on a miss, so no extra gating here.
  // The add is ADDR_W wide on purpose: carry out wraps the address.
  always_comb begin
    hit_valid_d = |s1_hit_q;
    hit_idx_d   = s1_idx_q;
    rom_addr_d  = s1_off_q + s1_inner_q;
    is_rom_d    = s1_attr_q[0];
    is_sram_d   = s1_attr_q[1];
    is_wr_d     = s1_attr_q[2];
    rom_hit_d   = s1_attr_q[0] | s1_attr_q[2];
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      rom_addr_q  <= '0;
      rom_hit_q   <= 1'b0;
      is_rom_q    <= 1'b0;
      is_sram_q   <= 1'b0;
      is_wr_q     <= 1'b0;
      hit_idx_q   <= '0;
      hit_valid_q <= 1'b0;
    end else begin
      rom_addr_q  <= rom_addr_d;
      rom_hit_q   <= rom_hit_d;
      is_rom_q    <= is_rom_d;
      is_sram_q   <= is_sram_d;
      is_wr_q     <= is_wr_d;
      hit_idx_q   <= hit_idx_d;
      hit_valid_q <= hit_valid_d;
    end
  end

  assign ROM_ADDR    = rom_addr_q;
  assign ROM_HIT     = rom_hit_q;
  assign IS_ROM      = is_rom_q;
  assign IS_SAVERAM  = is_sram_q;
  assign IS_WRITABLE = is_wr_q;
  assign HIT_IDX     = hit_idx_q;
  assign HIT_VALID   = hit_valid_q;

`ifdef ADDRMAP_HITCNT_EN
  logic        access_q;
  logic        access_d;
  logic [15:0] cnt_q [NUM_REGIONS];
  logic [15:0] cnt_d [NUM_REGIONS];
  logic [15:0] hitcnt_q;
  logic [15:0] hitcnt_d;
  logic        rd_idx_ok;

  assign rd_idx_ok = 32'(HITCNT_IDX) < 32'(NUM_REGIONS);

  // Counting follows the stage-1 sample; a commit copy clears all
  // counters and wins over an increment on the same edge.
  always_comb begin
    access_d = SNES_ACCESS;
    cnt_d    = cnt_q;
    if (copy) begin
      for (int i = 0; i < NUM_REGIONS; i++) begin
        cnt_d[i] = '0;
      end
    end else if (access_q && (|s1_hit_q)) begin
      if (cnt_q[s1_idx_q] != 16'hFFFF) begin
        cnt_d[s1_idx_q] = cnt_q[s1_idx_q] + 16'd1;
      end
    end
    hitcnt_d = rd_idx_ok ? cnt_q[HITCNT_IDX] : 16'h0;
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      access_q <= 1'b0;
      for (int i = 0; i < NUM_REGIONS; i++) begin
        cnt_q[i] <= '0;
      end
      hitcnt_q <= '0;
    end else begin
      access_q <= access_d;
      cnt_q    <= cnt_d;
      hitcnt_q <= hitcnt_d;
    end
  end

  assign HITCNT_DATA = hitcnt_q;
`else
  logic unused_hitcnt;

  assign unused_hitcnt = ^{HITCNT_IDX, SNES_ACCESS};
  assign HITCNT_DATA   = 16'h0;
`endif

endmodule
